block_transpose_buffer: RTL and testbench

- Streaming, parametrised N×N block transposer for the JPEG 2-D DCT/IDCT datapath, placed between the row-pass and column-pass 1-D transforms.
- Accepts one row of N W-bit coefficients per cycle and emits one column per cycle.
- Ping-pong double buffering sustains one row per cycle with no bubbles.
- A per-block mode bit selects transpose or pass-through, which the previous fixed 8×8/16-bit combinational mapping could not do.

---
 rtl/block_transpose_buffer_if.sv | 25 ++
 rtl/block_transpose_buffer.sv | 93 +++++++++
 tb/tb_block_transpose_buffer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/block_transpose_buffer_if.sv
// Row-in / beat-out stream bundle for the block transposer.
// The master drives rows in and takes beats out; the slave is the buffer itself.
interface block_transpose_buffer_if #(
    parameter int N = 8,
    parameter int W = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_data;
    logic           in_mode;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] out_data;
    logic           out_last;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/block_transpose_buffer.sv
// Ping-pong N x N block transposer sitting between the row and column DCT passes.
// Each block carries its own mode: 1 emits columns, 0 emits the rows unchanged.
module block_transpose_buffer #(
    parameter int N = 8,
    parameter int W = 16
) (
    input logic                    clk,
    input logic                    rst,
    block_transpose_buffer_if.slave bus
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic signed [W-1:0] mem [2][N][N];
    logic [1:0]          mode;

    logic          wb;
    logic          rb;
    logic [CW-1:0] wr;
    logic [CW-1:0] rc;
    logic [1:0]    full;
    logic [1:0]    full_nxt;
    logic          in_acc;
    logic          out_acc;

    // in_ready depends only on state, so the source never waits on out_ready.
    assign bus.in_ready  = rst || !full[wb];
    assign in_acc        = bus.in_valid && !full[wb];
    assign bus.out_valid = full[rb];
    assign out_acc       = full[rb] && bus.out_ready;
    assign bus.out_last  = full[rb] && (rc == LAST);

    // A set needs !full and a clear needs full, so they never hit the same bank.
    always_comb begin
        full_nxt = full;
        if (in_acc && wr == LAST) begin
            full_nxt[wb] = 1'b1;
        end
        if (out_acc && rc == LAST) begin
            full_nxt[rb] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb   <= 1'b0;
            wr   <= '0;
            rb   <= 1'b0;
            rc   <= '0;
            full <= '0;
        end else begin
            full <= full_nxt;
            if (in_acc) begin
                if (wr == LAST) begin
                    wb <= ~wb;
                    wr <= '0;
                end else begin
                    wr <= wr + CW'(1);
                end
            end
            if (out_acc) begin
                if (rc == LAST) begin
                    rb <= ~rb;
                    rc <= '0;
                end else begin
                    rc <= rc + CW'(1);
                end
            end
        end
    end

    // Block storage and per-block mode; stale contents are harmless once counters reset.
    always_ff @(posedge clk) begin
        if (in_acc) begin
            for (int c = 0; c < N; c++) begin
                mem[wb][wr][CW'(c)] <= bus.in_data[c*W +: W];
            end
            if (wr == '0) begin
                mode[wb] <= bus.in_mode;
            end
        end
    end

    always_comb begin
        bus.out_data = '0;
        if (full[rb]) begin
            for (int i = 0; i < N; i++) begin
                bus.out_data[i*W +: W] = mode[rb] ? mem[rb][CW'(i)][rc]
                                                  : mem[rb][rc][CW'(i)];
            end
        end
    end
endmodule

// File: tb/tb_block_transpose_buffer.sv
// Directed bench for block_transpose_buffer: transpose, pass-through, ping-pong,
// backpressure, input stalls and mid-block reset, against hand-derived beats.
`timescale 1ns/1ps
module tb_block_transpose_buffer;
    localparam int N  = 8;
    localparam int W  = 16;
    localparam int DW = N * W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    block_transpose_buffer_if #(.N(N), .W(W)) bus ();

    block_transpose_buffer #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    n_checks = 0;
    int    n_fail   = 0;
    int    gaps     = 0;
    int    extra    = 0;
    int    idle_bad = 0;
    bit    watch_gaps = 1'b0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Element (r,c) of a block is base + 16r + c.
    function automatic logic [DW-1:0] row_of(input int base, input int r);
        logic [DW-1:0] d;
        for (int c = 0; c < N; c++) d[c*W +: W] = W'(base + 16*r + c);
        return d;
    endfunction

    task automatic push_block(input int base, input bit m);
        beat_t b;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++)
                b.data[i*W +: W] = m ? W'(base + 16*i + k) : W'(base + 16*k + i);
            b.last = (k == N - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the row is taken.
    task automatic send_row(input logic [DW-1:0] d, input bit m, output int stalls);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_mode  = m;
        stalls = 0;
        @(negedge clk);
        while (!bus.in_ready && stalls < 1000) begin
            stalls++;
            @(negedge clk);
        end
        if (!bus.in_ready) chk("row_accept_timeout", DW'(bus.in_ready), DW'(1));
        sync();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_block(input int base, input bit m, input int max_gap,
                              input bit toggle, output int stalls);
        int s;
        stalls = 0;
        for (int r = 0; r < N; r++) begin
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) begin
                    bus.in_data = {DW{1'b1}};
                    sync();
                end
            end
            send_row(row_of(base, r), (toggle && r != 0) ? ~m : m, s);
            stalls += s;
        end
    endtask

    task automatic wait_drain(output int n);
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        watch_gaps = 1'b0;
        chk("drain_remaining", DW'(exp_q.size()), DW'(0));
        sync();
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                extra++;
            end else begin
                mon_e = exp_q.pop_front();
                chk("beat_data", bus.out_data, mon_e.data);
                chk("beat_last", DW'(bus.out_last), DW'(mon_e.last));
            end
        end
        if (!rst && !bus.out_valid && (bus.out_data != '0 || bus.out_last)) idle_bad++;
        if (watch_gaps && !bus.out_valid) gaps++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int st;
        int s;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) sync();
        chk("rst_in_ready", DW'(bus.in_ready), DW'(1));
        chk("rst_out_valid", DW'(bus.out_valid), DW'(0));
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_out_last", DW'(bus.out_last), DW'(0));
        rst = 1'b0;
        sync();
        chk("idle_in_ready", DW'(bus.in_ready), DW'(1));

        // Transpose at full throughput
        bus.out_ready = 1'b1;
        push_block(0, 1'b1);
        for (int r = 0; r < N - 1; r++) send_row(row_of(0, r), 1'b1, s);
        chk("t1_valid_before_row7", DW'(bus.out_valid), DW'(0));
        send_row(row_of(0, N - 1), 1'b1, s);
        chk("t1_valid_after_row7", DW'(bus.out_valid), DW'(1));
        wait_drain(n);
        chk("t1_gapless_beats", DW'(n), DW'(8));

        // Pass-through
        push_block(32'h1000, 1'b0);
        send_block(32'h1000, 1'b0, 0, 1'b0, st);
        chk("t2_valid_after_row7", DW'(bus.out_valid), DW'(1));
        wait_drain(n);
        chk("t2_gapless_beats", DW'(n), DW'(8));

        // Ping-pong streaming, alternating modes
        push_block(32'h2000, 1'b1);
        push_block(32'h3000, 1'b0);
        push_block(32'h4000, 1'b1);
        push_block(32'h5000, 1'b0);
        gaps = 0;
        send_block(32'h2000, 1'b1, 0, 1'b0, st);
        watch_gaps = 1'b1;
        for (int b = 1; b < 4; b++) begin
            send_block(32'h2000 + 32'h1000 * b, (b % 2) == 0, 0, 1'b0, s);
            st += s;
        end
        wait_drain(n);
        chk("t3_in_ready_stalls", DW'(st), DW'(0));
        chk("t3_output_gaps", DW'(gaps), DW'(0));

        // Backpressure: two blocks fill both banks, the third waits
        bus.out_ready = 1'b0;
        push_block(32'h6000, 1'b1);
        push_block(32'h7000, 1'b0);
        push_block(32'h0800, 1'b1);
        send_block(32'h6000, 1'b1, 0, 1'b0, st);
        send_block(32'h7000, 1'b0, 0, 1'b0, s);
        st += s;
        chk("t4_no_stall_16_rows", DW'(st), DW'(0));
        chk("t4_in_ready_low", DW'(bus.in_ready), DW'(0));
        chk("t4_out_valid", DW'(bus.out_valid), DW'(1));
        chk("t4_hold_beat0", bus.out_data, exp_q[0].data);
        repeat (5) sync();
        chk("t4_hold_beat0_later", bus.out_data, exp_q[0].data);
        chk("t4_hold_last", DW'(bus.out_last), DW'(0));
        chk("t4_in_ready_still_low", DW'(bus.in_ready), DW'(0));
        fork
            send_block(32'h0800, 1'b1, 0, 1'b0, s);
            begin
                for (int i = 0; i < 2000 && exp_q.size() != 0; i++) begin
                    sync();
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_drain(n);
        chk("t4_no_extra", DW'(extra), DW'(0));

        // Input stalls; in_mode toggled on rows 1-7 must be ignored
        bus.out_ready = 1'b1;
        push_block(32'h0100, 1'b1);
        push_block(32'h0200, 1'b0);
        send_block(32'h0100, 1'b1, 3, 1'b1, s);
        send_block(32'h0200, 1'b0, 3, 1'b1, s);
        wait_drain(n);

        // Mid-block reset: one stored block, five rows of the next, input pending
        bus.out_ready = 1'b0;
        send_block(32'h0300, 1'b1, 0, 1'b0, s);
        for (int r = 0; r < 5; r++) send_row(row_of(32'h0400, r), 1'b0, s);
        bus.in_valid = 1'b1;
        bus.in_data  = row_of(32'h0400, 5);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_in_ready_in_rst", DW'(bus.in_ready), DW'(1));
        sync();
        chk("t6_out_valid_after_rst", DW'(bus.out_valid), DW'(0));
        chk("t6_out_data_after_rst", bus.out_data, '0);
        chk("t6_out_last_after_rst", DW'(bus.out_last), DW'(0));
        rst = 1'b0;
        bus.in_valid = 1'b0;
        sync();
        chk("t6_in_ready_after_rst", DW'(bus.in_ready), DW'(1));

        // Reset with both banks full still raises in_ready
        send_block(32'h0500, 1'b1, 0, 1'b0, s);
        send_block(32'h0600, 1'b1, 0, 1'b0, s);
        chk("t6_both_full_ready", DW'(bus.in_ready), DW'(0));
        rst = 1'b1;
        @(negedge clk);
        chk("t6_full_in_ready_in_rst", DW'(bus.in_ready), DW'(1));
        sync();
        chk("t6_full_valid_after_rst", DW'(bus.out_valid), DW'(0));
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) sync();
        chk("t6_no_beats_after_rst", DW'(extra), DW'(0));
        push_block(32'h0700, 1'b1);
        send_block(32'h0700, 1'b1, 0, 1'b0, s);
        wait_drain(n);
        chk("t6_fresh_gapless", DW'(n), DW'(8));

        chk("final_no_extra", DW'(extra), DW'(0));
        chk("idle_outputs_zero", DW'(idle_bad), DW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
